// File: rtl/rr_csr_axil_master_pkg.sv
// Shared rr definitions for the CSR AXI-Lite master: CSR index width,
// FSM state encoding and the captured command record.
package rr_csr_axil_master_pkg;

    localparam int unsigned RR_CSR_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RRESP,
        RSP
    } rr_csr_axil_master_state_e;

    typedef struct packed {
        logic                         write;
        logic [RR_CSR_ADDR_WIDTH-1:0] idx;
        logic [31:0]                  wdata;
        logic [3:0]                   wstrb;
    } rr_csr_cmd_t;

    // States in which a bus transaction is outstanding on AXI-Lite
    function automatic logic is_busy(input rr_csr_axil_master_state_e s);
        return (s == WRITE) || (s == WRESP) || (s == READ) || (s == RRESP);
    endfunction

endpackage

// File: rtl/rr_axi_lite_bus.sv
// AXI-Lite bus bundle (32-bit data) with initiator and target views.
interface rr_axi_lite_bus_t #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport initiator (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport target (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rr_csr_axil_master.sv
// Single-outstanding CSR command to AXI-Lite master with registered outputs.
// Optional transaction watchdog: define RR_CSR_AXIL_MASTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command (drains stray B/R after a timeout)
// WRITE | awvalid/wvalid driven, each dropped on its own handshake
// WRESP | bready high, waiting for the write response
// READ  | arvalid driven, waiting for the AR handshake
// RRESP | rready high, waiting for read data
// RSP   | rsp_valid high with stable payload until rsp_ready
module rr_csr_axil_master
    import rr_csr_axil_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [RR_CSR_ADDR_WIDTH-1:0] cmd_idx,
    input  logic [31:0]                  cmd_wdata,
    input  logic [3:0]                   cmd_wstrb,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic                         rsp_timeout,
    rr_axi_lite_bus_t.initiator          rr_cfg_bus
);

    rr_csr_axil_master_state_e state_q, state_d;
    rr_csr_cmd_t               cmd_q, cmd_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      aw_done, w_done, xfer_done;

`ifdef RR_CSR_AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             drain_q, drain_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             busy;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        aw_done     = !awvalid_q || rr_cfg_bus.awready;
        w_done      = !wvalid_q || rr_cfg_bus.wready;
        xfer_done   = ((state_q == WRESP) && bready_q && rr_cfg_bus.bvalid) ||
                      ((state_q == RRESP) && rready_q && rr_cfg_bus.rvalid);

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d.write = cmd_write;
                    cmd_d.idx   = cmd_idx;
                    cmd_d.wdata = cmd_wdata;
                    cmd_d.wstrb = cmd_wstrb;
                    bready_d    = 1'b0;
                    rready_d    = 1'b0;
                    if (cmd_write) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (rr_cfg_bus.awready) awvalid_d = 1'b0;
                if (rr_cfg_bus.wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (xfer_done) begin
                    state_d  = RSP;
                    bready_d = 1'b0;
                end
            end
            READ: begin
                if (rr_cfg_bus.arready) begin
                    state_d   = RRESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RRESP: begin
                if (xfer_done) begin
                    state_d  = RSP;
                    rready_d = 1'b0;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (xfer_done) begin
            rsp_rdata_d = cmd_q.write ? 32'h0 : rr_cfg_bus.rdata;
            rsp_resp_d  = cmd_q.write ? rr_cfg_bus.bresp : rr_cfg_bus.rresp;
        end

`ifdef RR_CSR_AXIL_MASTER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        drain_d       = drain_q;
        rsp_timeout_d = rsp_timeout_q;
        busy          = is_busy(state_q);
        if (xfer_done) rsp_timeout_d = 1'b0;
        if (busy && (tmo_cnt_q < CNT_W'(TIMEOUT_CYCLES))) tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A handshake that advances the FSM in the expiry cycle wins over the abort
        if (busy && (state_d == state_q) && (tmo_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_rdata_d   = 32'h0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            drain_d       = 1'b1;
        end
        if (state_d == IDLE) tmo_cnt_d = '0;
        if ((state_q == IDLE) && (state_d != IDLE)) drain_d = 1'b0;
        if ((state_d == IDLE) && drain_d) begin
            bready_d = 1'b1;
            rready_d = 1'b1;
        end
`endif

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_resp_q    <= 2'b00;
`ifdef RR_CSR_AXIL_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            drain_q       <= 1'b0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
`ifdef RR_CSR_AXIL_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            drain_q       <= drain_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_resp   = rsp_resp_q;
`ifdef RR_CSR_AXIL_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign rr_cfg_bus.awvalid = awvalid_q;
    assign rr_cfg_bus.awaddr  = ADDR_WIDTH'({cmd_q.idx, 2'b00});
    assign rr_cfg_bus.wvalid  = wvalid_q;
    assign rr_cfg_bus.wdata   = cmd_q.wdata;
    assign rr_cfg_bus.wstrb   = cmd_q.wstrb;
    assign rr_cfg_bus.bready  = bready_q;
    assign rr_cfg_bus.arvalid = arvalid_q;
    assign rr_cfg_bus.araddr  = ADDR_WIDTH'({cmd_q.idx, 2'b00});
    assign rr_cfg_bus.rready  = rready_q;

endmodule

// File: tb/tb_rr_csr_axil_master.sv
// Directed bench for rr_csr_axil_master with a small AXI-Lite slave model.
// Timeout scenario runs only when RR_CSR_AXIL_MASTER_TIMEOUT_EN is defined.
module tb_rr_csr_axil_master;
    import rr_csr_axil_master_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 16;

    logic                         clk = 1'b0;
    logic                         rstn;
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_write;
    logic [RR_CSR_ADDR_WIDTH-1:0] cmd_idx;
    logic [31:0]                  cmd_wdata;
    logic [3:0]                   cmd_wstrb;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [31:0]                  rsp_rdata;
    logic [1:0]                   rsp_resp;
    logic                         rsp_timeout;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic slv_en_b, slv_en_r, inject_r, aw_seen, w_seen;

    rr_axi_lite_bus_t #(.ADDR_WIDTH(AW)) bus ();

    rr_csr_axil_master #(.TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_idx    (cmd_idx),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .rsp_timeout(rsp_timeout),
        .rr_cfg_bus (bus.initiator)
    );

    always #5 clk = ~clk;

    // Slave: B one edge after both AW and W handshakes, R one edge after AR
    always @(posedge clk) begin
        if (!rstn) begin
            bus.bvalid <= 1'b0;
            bus.rvalid <= 1'b0;
            aw_seen    <= 1'b0;
            w_seen     <= 1'b0;
        end else begin
            if (bus.awvalid && bus.awready) aw_seen <= 1'b1;
            if (bus.wvalid && bus.wready)   w_seen  <= 1'b1;
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
            end else if (!bus.bvalid && slv_en_b &&
                         (aw_seen || (bus.awvalid && bus.awready)) &&
                         (w_seen || (bus.wvalid && bus.wready))) begin
                bus.bvalid <= 1'b1;
                aw_seen    <= 1'b0;
                w_seen     <= 1'b0;
            end
            if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
            end else if ((bus.arvalid && bus.arready && slv_en_r) || inject_r) begin
                bus.rvalid <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command; returns just after the accept edge
    task automatic issue(input logic wr, input logic [RR_CSR_ADDR_WIDTH-1:0] idx,
                         input logic [31:0] wd, input logic [3:0] ws);
        int n = 0;
        cmd_write = wr;
        cmd_idx   = idx;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        vec_cnt++;
        if (!cmd_ready) begin
            err_cnt++;
            $display("FAIL issue_accept: cmd_ready stayed %b, required 1 within 20 cycles", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    // Edges after the accept edge until rsp_valid is seen (bounded)
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vec_cnt++; if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin err_cnt++; $display("FAIL reset_payload: got %h/%h/%b want 0", rsp_rdata, rsp_resp, rsp_timeout); end
        vec_cnt++; if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin err_cnt++; $display("FAIL reset_axi: got %b want 00000", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}); end
        rstn = 1'b1;
        step();
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    // Accept cycle counts as cycle 1, so rsp_valid shows in cycle 4 (two edges after accept)
    task automatic test_write_ideal();
        int lat;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bresp = 2'b00;
        issue(1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
        vec_cnt++; if ({bus.awvalid, bus.wvalid} !== 2'b11) begin err_cnt++; $display("FAIL wr_valids: got %b want 11", {bus.awvalid, bus.wvalid}); end
        vec_cnt++; if (bus.awaddr !== 32'h14) begin err_cnt++; $display("FAIL wr_awaddr: got %h want 00000014", bus.awaddr); end
        vec_cnt++; if ({bus.wdata, bus.wstrb} !== {32'hDEADBEEF, 4'hF}) begin err_cnt++; $display("FAIL wr_wdata: got %h/%h want deadbeef/f", bus.wdata, bus.wstrb); end
        wait_rsp(lat);
        vec_cnt++; if (lat != 2) begin err_cnt++; $display("FAIL wr_latency: got %0d edges want 2", lat); end
        vec_cnt++; if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin err_cnt++; $display("FAIL wr_rsp: got %h/%h/%b want 0/0/0", rsp_rdata, rsp_resp, rsp_timeout); end
        vec_cnt++; if (bus.bready !== 1'b0) begin err_cnt++; $display("FAIL wr_bready_rsp: got %b want 0", bus.bready); end
        consume();
        vec_cnt++; if ({rsp_valid, cmd_ready} !== 2'b01) begin err_cnt++; $display("FAIL wr_done: got %b want 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_read();
        int lat;
        bus.arready = 1'b1; slv_en_r = 1'b1; bus.rdata = 32'h00000064; bus.rresp = 2'b00;
        issue(1'b0, 8'd3, 32'h0, 4'h0);
        vec_cnt++; if ({bus.arvalid, bus.awvalid} !== 2'b10) begin err_cnt++; $display("FAIL rd_valids: got %b want 10", {bus.arvalid, bus.awvalid}); end
        vec_cnt++; if (bus.araddr !== 32'h0C) begin err_cnt++; $display("FAIL rd_araddr: got %h want 0000000c", bus.araddr); end
        wait_rsp(lat);
        vec_cnt++; if (lat != 2) begin err_cnt++; $display("FAIL rd_latency: got %0d edges want 2", lat); end
        vec_cnt++; if ({rsp_rdata, rsp_resp} !== {32'h64, 2'b00}) begin err_cnt++; $display("FAIL rd_rsp: got %h/%h want 00000064/0", rsp_rdata, rsp_resp); end
        consume();
    endtask

    task automatic test_w_before_aw();
        int lat;
        int extra = 0;
        bus.awready = 1'b0; bus.wready = 1'b1; bus.bresp = 2'b01;
        issue(1'b1, 8'h21, 32'h12345678, 4'b0011);
        vec_cnt++; if (bus.awaddr !== 32'h84) begin err_cnt++; $display("FAIL wfirst_awaddr: got %h want 00000084", bus.awaddr); end
        step();
        vec_cnt++; if ({bus.awvalid, bus.wvalid} !== 2'b10) begin err_cnt++; $display("FAIL wfirst_w_drop: got %b want 10", {bus.awvalid, bus.wvalid}); end
        step();
        step();
        vec_cnt++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b100) begin err_cnt++; $display("FAIL wfirst_aw_hold: got %b want 100", {bus.awvalid, bus.wvalid, bus.bready}); end
        bus.awready = 1'b1;
        step();
        vec_cnt++; if ({bus.awvalid, bus.bready} !== 2'b01) begin err_cnt++; $display("FAIL wfirst_wresp: got %b want 01", {bus.awvalid, bus.bready}); end
        wait_rsp(lat);
        vec_cnt++; if ({rsp_valid, rsp_rdata, rsp_resp} !== {1'b1, 32'h0, 2'b01}) begin err_cnt++; $display("FAIL wfirst_rsp: got %b/%h/%h want 1/0/1", rsp_valid, rsp_rdata, rsp_resp); end
        consume();
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) extra++;
            step();
        end
        vec_cnt++; if (extra != 0) begin err_cnt++; $display("FAIL wfirst_single_rsp: got %0d extra cycles of rsp_valid want 0", extra); end
    endtask

    task automatic test_rsp_backpressure();
        int lat;
        bus.rdata = 32'hA5A50001; bus.rresp = 2'b11;
        issue(1'b0, 8'hFF, 32'h0, 4'h0);
        vec_cnt++; if (bus.araddr !== 32'h3FC) begin err_cnt++; $display("FAIL bp_araddr: got %h want 000003fc", bus.araddr); end
        wait_rsp(lat);
        cmd_write = 1'b1; cmd_idx = 8'h01; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vec_cnt++;
            if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp} !== {2'b10, 32'hA5A50001, 2'b11}) begin
                err_cnt++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %h/%h want v=1 rdy=0 a5a50001/3", i, rsp_valid, cmd_ready, rsp_rdata, rsp_resp);
            end
        end
        consume();
        vec_cnt++; if ({rsp_valid, cmd_ready, bus.awvalid} !== 3'b010) begin err_cnt++; $display("FAIL bp_no_bypass: got %b want 010", {rsp_valid, cmd_ready, bus.awvalid}); end
        cmd_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_wresp();
        int seen = 0;
        slv_en_b = 1'b0; bus.bresp = 2'b00;
        issue(1'b1, 8'd1, 32'hCAFE0000, 4'hF);
        step();
        vec_cnt++; if (bus.bready !== 1'b1) begin err_cnt++; $display("FAIL rst_wresp_bready: got %b want 1", bus.bready); end
        step();
        rstn = 1'b0;
        step();
        vec_cnt++; if ({bus.bready, rsp_valid, cmd_ready} !== 3'b000) begin err_cnt++; $display("FAIL rst_wresp_clear: got %b want 000", {bus.bready, rsp_valid, cmd_ready}); end
        rstn = 1'b1;
        slv_en_b = 1'b1;
        step();
        vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_wresp_ready: got %b want 1", cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen++;
            step();
        end
        vec_cnt++; if (seen != 0) begin err_cnt++; $display("FAIL rst_wresp_no_rsp: got %0d response cycles want 0", seen); end
    endtask

`ifdef RR_CSR_AXIL_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        bus.arready = 1'b1; slv_en_r = 1'b0;
        issue(1'b0, 8'd2, 32'h0, 4'h0);
        wait_rsp(lat);
        vec_cnt++; if (lat != 16) begin err_cnt++; $display("FAIL tmo_latency: got %0d edges want 16", lat); end
        vec_cnt++; if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b10, 1'b1, 32'h0}) begin err_cnt++; $display("FAIL tmo_rsp: got %b/%h/%b/%h want 1/2/1/0", rsp_valid, rsp_resp, rsp_timeout, rsp_rdata); end
        vec_cnt++; if ({bus.arvalid, bus.rready} !== 2'b00) begin err_cnt++; $display("FAIL tmo_axi_idle: got %b want 00", {bus.arvalid, bus.rready}); end
        consume();
        vec_cnt++; if ({bus.bready, bus.rready} !== 2'b11) begin err_cnt++; $display("FAIL tmo_drain: got %b want 11", {bus.bready, bus.rready}); end
        inject_r = 1'b1;
        step();
        inject_r = 1'b0;
        step();
        vec_cnt++; if ({bus.rvalid, rsp_valid} !== 2'b00) begin err_cnt++; $display("FAIL tmo_stray_r: got %b want 00", {bus.rvalid, rsp_valid}); end
        slv_en_r = 1'b1; bus.rdata = 32'h77; bus.rresp = 2'b00;
        issue(1'b0, 8'd4, 32'h0, 4'h0);
        wait_rsp(lat);
        vec_cnt++; if ({lat[3:0], rsp_timeout, rsp_rdata} !== {4'd2, 1'b0, 32'h77}) begin err_cnt++; $display("FAIL tmo_recover: got lat=%0d to=%b %h want 2/0/00000077", lat, rsp_timeout, rsp_rdata); end
        consume();
    endtask
`endif

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_idx = '0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        slv_en_b = 1'b1; slv_en_r = 1'b1; inject_r = 1'b0;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.arready = 1'b1;
        bus.bresp = 2'b00; bus.rdata = 32'h0; bus.rresp = 2'b00;
        test_reset();
        test_write_ideal();
        test_read();
        test_w_before_aw();
        test_rsp_backpressure();
        test_reset_in_wresp();
`ifdef RR_CSR_AXIL_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rr_csr_axil_master.md
RR_CSR_AXIL_MASTER -- requirements
Module: rr_csr_axil_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles allowed per transaction before abort (TIMEOUT_EN only).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI-Lite address width.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rstn, input, 1: synchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when both valid and ready are high.
REQ-007 SHALL have port cmd_write, input, 1: 1=write, 0=read.
REQ-008 SHALL have port cmd_idx, input, RR_CSR_ADDR_WIDTH: CSR index.
REQ-009 SHALL have port cmd_wdata, input, 32: write data.
REQ-010 SHALL have port cmd_wstrb, input, 4: byte strobes.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: response consumed.
REQ-013 SHALL have port rsp_rdata, output, 32: read data; 0 for writes.
REQ-014 SHALL have port rsp_resp, output, 2: AXI response code.
REQ-015 SHALL have port rsp_timeout, output, 1: transaction aborted by timeout.
REQ-016 SHALL have port rr_cfg_bus, rr_axi_lite_bus_t, initiator-side modport: drives awvalid/awaddr/wvalid/wdata/wstrb/bready/arvalid/araddr/rready.

Function
REQ-017 SHALL allow one outstanding transaction; cmd_ready=1 only in IDLE.
REQ-018 SHALL implement states IDLE, WRITE, WRESP, READ, RRESP, RSP.
REQ-019 SHALL on write accept: register data, enter WRITE, assert awvalid and wvalid the next cycle, awaddr={cmd_idx,2'b00} zero-extended to ADDR_WIDTH.
REQ-020 SHALL in WRITE drop awvalid and wvalid independently on their own handshakes; either order, or both in one cycle, is legal; enter WRESP when both are done.
REQ-021 SHALL in WRESP hold bready=1; on the B handshake capture bresp, set rsp_rdata=0, and enter RSP.
REQ-022 SHALL on read accept: enter READ and assert arvalid the next cycle with araddr={cmd_idx,2'b00}; on the AR handshake enter RRESP.
REQ-023 SHALL in RRESP hold rready=1; on the R handshake capture rdata/rresp and enter RSP.
REQ-024 SHALL in RSP hold rsp_valid=1 with stable payload until rsp_ready, then return to IDLE; no bypass from RSP to a new command in the same cycle.
REQ-025 SHALL never assert bready/rready outside WRESP/RRESP, except the drain in REQ-032.
REQ-026 SHALL have minimum latency (ideal slave, ready always high) of 4 cycles from cmd accept to rsp_valid for both reads and writes.

Reset
REQ-027 SHALL, while rstn=0 at clk, force IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, all AXI valids/readies=0, and timeout counter=0.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation without emitting a response; cmd_ready=1 from the first cycle after reset release.

Configuration
REQ-029 SHALL compile the timeout watchdog only when RR_CSR_AXIL_MASTER_TIMEOUT_EN is defined.
REQ-030 SHALL, with the macro: count cycles spent in WRITE/WRESP/READ/RRESP from 0, reset to 0 on entry to IDLE, saturate at TIMEOUT_CYCLES.
REQ-031 SHALL, with the macro, on reaching TIMEOUT_CYCLES: deassert all AXI valids, enter RSP with rsp_resp=2'b10 and rsp_timeout=1; a handshake in that same cycle takes precedence over the timeout.
REQ-032 SHALL, with the macro, accept and drop stray B/R beats arriving in IDLE after a timeout (bready=rready=1 there).
REQ-033 SHALL, without the macro: tie rsp_timeout to 0, wait indefinitely, and include no counter logic.

Structure
REQ-034 SHALL place rr_csr_axil_master_state_e and an rr_csr_cmd_t struct (write, idx, wdata, wstrb) in the shared rr defs package, alongside RR_CSR_ADDR_WIDTH.
REQ-035 SHALL be a single module with no sub-modules.

Verification
REQ-036 Write idx 5, data 0xDEADBEEF, strb 0xF, slave always ready -> awaddr=0x14, rsp_valid 4 cycles after accept, resp 0, rdata 0.
REQ-037 Read idx 3, slave returns 0x00000064 with OKAY -> araddr=0x0C, rsp_rdata=0x64, rsp_resp=0.
REQ-038 Write with wready asserted 3 cycles before awready -> wvalid drops first, awvalid holds, exactly one response.
REQ-039 rsp_ready low for 10 cycles -> rsp_valid and payload stable, cmd_ready=0 throughout.
REQ-040 Macro on, TIMEOUT_CYCLES=16, slave never answers a read -> rsp_valid after 16 counted cycles, resp=2'b10, rsp_timeout=1; a later stray R is dropped.
REQ-041 rstn pulsed low while in WRESP -> no response emitted; cmd_ready=1 the cycle after release.
